spi_mux_master: RTL and testbench

//  CSR-driven SPI master. The processor writes one command word, and the block shifts it out to one of
//  N_DEV SPI slaves, then returns the read-back word in its status CSR.
//  The slave is chosen by muxSel, which comes from the SPI MUX selection GPIO register.

---
 rtl/spi_mux_pkg.sv | 29 ++
 rtl/spi_mux_master_tick.sv | 28 ++
 rtl/spi_mux_master.sv | 191 +++++++++++++++++++
 tb/tb_spi_mux_master.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mux_pkg.sv
// Shared definitions for the CSR-driven SPI mux master: status bit layout,
// command field positions and FSM state encoding.
package spi_mux_pkg;

    localparam int BUSY_BIT     = 31;
    localparam int OVR_BIT      = 30;
    localparam int BADSEL_BIT   = 29;

    localparam int CMD_NBITS_HI = 28;
    localparam int CMD_NBITS_LO = 24;
    localparam int MAX_BITS     = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD
    } state_t;

    // Command field holds nBits-1; anything past the shifter width saturates.
    function automatic logic [4:0] clamp_nbits(input logic [4:0] field);
        if (field >= 5'(MAX_BITS - 1)) begin
            return 5'(MAX_BITS);
        end
        return field + 5'd1;
    endfunction

endpackage

// File: rtl/spi_mux_master_tick.sv
// Half-period timer: reloads on every phase entry and raises o_tick during
// the last cycle of a CLK_DIV-cycle phase.
module spi_half_period_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= CNT_W'(CLK_DIV - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_mux_master.sv
// SPI mode-0 master driven by a single CSR command word; routes the transfer
// to the slave chosen by muxSel at acceptance and reports rx data in sysCsr.
module spi_mux_master
    import spi_mux_pkg::*;
#(
    parameter int N_DEV   = 4,
    parameter int SEL_W   = 2,
    parameter int CLK_DIV = 4
) (
    input  logic              sysClk,
    input  logic              sysReset,
    input  logic              sysCsrStrobe,
    input  logic [31:0]       sysGpioOut,
    output logic [31:0]       sysCsr,
    input  logic [SEL_W-1:0]  muxSel,
    output logic              spiClk,
    output logic              spiMosi,
    output logic [N_DEV-1:0]  spiCsN,
    input  logic [N_DEV-1:0]  spiMiso
);

    state_t              r_state;
    state_t              w_state_next;

    logic [MAX_BITS-1:0] r_tx;
    logic [MAX_BITS-1:0] r_rx_shift;
    logic [MAX_BITS-1:0] r_rx;
    logic [4:0]          r_bits_left;
    logic [SEL_W-1:0]    r_sel;
    logic                r_badsel;
    logic                r_ovr;
    logic                r_mosi;

    logic                w_tick;
    logic                w_phase_start;
    logic                w_accept;
    logic                w_enter_high;
    logic                w_enter_low;
    logic                w_done;
    logic                w_miso;
    logic                w_cs_active;
    logic                w_sel_bad;
    logic [4:0]          w_nbits;
    logic [MAX_BITS-1:0] w_tx_aligned;
    logic                w_unused_cmd;

    assign w_unused_cmd = ^sysGpioOut[31:29];

    spi_half_period_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk     (sysClk),
        .i_rst     (sysReset),
        .i_restart (w_phase_start),
        .o_tick    (w_tick)
    );

    // Left-align the tx word so the first bit out is always r_tx[MSB].
    assign w_nbits      = clamp_nbits(sysGpioOut[CMD_NBITS_HI:CMD_NBITS_LO]);
    assign w_tx_aligned = sysGpioOut[MAX_BITS-1:0] << (5'(MAX_BITS) - w_nbits);
    assign w_sel_bad    = (32'(muxSel) >= N_DEV);

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_phase_start = 1'b0;
        w_accept      = 1'b0;
        w_enter_high  = 1'b0;
        w_enter_low   = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sysCsrStrobe) begin
                    w_state_next  = ST_SETUP;
                    w_accept      = 1'b1;
                    w_phase_start = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_next  = ST_HIGH;
                    w_enter_high  = 1'b1;
                    w_phase_start = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_state_next  = ST_LOW;
                    w_enter_low   = 1'b1;
                    w_phase_start = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    w_phase_start = 1'b1;
                    if (r_bits_left != 5'd0) begin
                        w_state_next = ST_HIGH;
                        w_enter_high = 1'b1;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_tx        <= '0;
            r_rx_shift  <= '0;
            r_rx        <= '0;
            r_bits_left <= '0;
            r_sel       <= '0;
            r_badsel    <= 1'b0;
            r_ovr       <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            if (sysCsrStrobe && (r_state != ST_IDLE)) begin
                r_ovr <= 1'b1;
            end
            if (w_accept) begin
                r_tx        <= w_tx_aligned;
                r_bits_left <= w_nbits;
                r_sel       <= muxSel;
                r_badsel    <= w_sel_bad;
                r_ovr       <= 1'b0;
                r_rx_shift  <= '0;
                r_rx        <= '0;
                r_mosi      <= w_tx_aligned[MAX_BITS-1];
            end
            if (w_enter_high) begin
                r_rx_shift  <= {r_rx_shift[MAX_BITS-2:0], w_miso};
                r_bits_left <= r_bits_left - 5'd1;
            end
            // The LOW after the final rising edge has no next bit; MOSI just holds.
            if (w_enter_low && (r_bits_left != 5'd0)) begin
                r_tx   <= {r_tx[MAX_BITS-2:0], 1'b0};
                r_mosi <= r_tx[MAX_BITS-2];
            end
            if (w_done) begin
                r_rx   <= r_rx_shift;
                r_mosi <= 1'b0;
            end
        end
    end

    always_comb begin
        w_miso = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if (!r_badsel && (r_sel == SEL_W'(i))) begin
                w_miso = spiMiso[i];
            end
        end
    end

    assign w_cs_active = (r_state != ST_IDLE) && !r_badsel;

    generate
        for (genvar gi = 0; gi < N_DEV; gi++) begin : g_cs
            assign spiCsN[gi] = !(w_cs_active && (r_sel == SEL_W'(gi)));
        end
    endgenerate

    assign spiClk  = (r_state == ST_HIGH);
    assign spiMosi = r_mosi;

    always_comb begin
        sysCsr                = '0;
        sysCsr[BUSY_BIT]      = (r_state != ST_IDLE);
        sysCsr[OVR_BIT]       = r_ovr;
        sysCsr[BADSEL_BIT]    = r_badsel;
        sysCsr[MAX_BITS-1:0]  = r_rx;
    end

endmodule

// File: tb/tb_spi_mux_master.sv
// Self-checking bench for spi_mux_master: behavioural mode-0 slaves, a
// scoreboard of expected transfer results and per-scenario test tasks.
module tb_spi_mux_master;

    localparam int N_DEV   = 3;
    localparam int SEL_W   = 2;
    localparam int CLK_DIV = 4;

    logic              sysClk = 1'b0;
    logic              sysReset;
    logic              sysCsrStrobe;
    logic [31:0]       sysGpioOut;
    logic [31:0]       sysCsr;
    logic [SEL_W-1:0]  muxSel;
    logic              spiClk;
    logic              spiMosi;
    logic [N_DEV-1:0]  spiCsN;
    logic [N_DEV-1:0]  spiMiso;

    always #5 sysClk = ~sysClk;

    spi_mux_master #(
        .N_DEV   (N_DEV),
        .SEL_W   (SEL_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .sysClk       (sysClk),
        .sysReset     (sysReset),
        .sysCsrStrobe (sysCsrStrobe),
        .sysGpioOut   (sysGpioOut),
        .sysCsr       (sysCsr),
        .muxSel       (muxSel),
        .spiClk       (spiClk),
        .spiMosi      (spiMosi),
        .spiCsN       (spiCsN),
        .spiMiso      (spiMiso)
    );

    typedef struct {
        logic [23:0]      rx;
        logic [23:0]      mosi;
        int               nb;
        int               busy_cycles;
        logic             badsel;
        logic [N_DEV-1:0] csn;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [23:0]      slave_pat [N_DEV];
    int               rise_cnt = 0;
    int               cur_nb = 1;
    logic [23:0]      mosi_cap = '0;
    int               busy_cnt = 0;
    int               cs_err = 0;
    logic [N_DEV-1:0] exp_csn = '1;
    logic             exp_ovr = 1'b0;

    // Mode-0 slaves: present bit (nb-1-k) before rising edge k.
    always_comb begin
        spiMiso = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (rise_cnt < cur_nb) begin
                spiMiso[i] = slave_pat[i][cur_nb - 1 - rise_cnt];
            end
        end
    end

    always @(posedge spiClk) mosi_cap = {mosi_cap[22:0], spiMosi};
    always @(negedge spiClk) rise_cnt = rise_cnt + 1;

    always @(negedge sysClk) begin
        if (sysCsr[31] === 1'b1) begin
            busy_cnt = busy_cnt + 1;
            if (spiCsN !== exp_csn) cs_err = cs_err + 1;
        end else if (spiCsN !== '1) begin
            cs_err = cs_err + 1;
        end
    end

    task automatic start_xfer(input logic [31:0] cmd, input logic [SEL_W-1:0] sel);
        exp_t        e;
        int          nb;
        logic [23:0] mask;
        nb = int'(cmd[28:24]) + 1;
        if (nb > 24) nb = 24;
        mask = (nb == 24) ? 24'hFFFFFF : ((24'd1 << nb) - 24'd1);
        e.nb          = nb;
        e.badsel      = (int'(sel) >= N_DEV);
        e.mosi        = cmd[23:0] & mask;
        e.rx          = e.badsel ? 24'd0 : (slave_pat[sel] & mask);
        e.busy_cycles = (2 * nb + 2) * CLK_DIV;
        e.csn         = e.badsel ? '1 : ~(N_DEV'(1) << sel);
        exp_q.push_back(e);
        @(negedge sysClk);
        sysGpioOut   = cmd;
        muxSel       = sel;
        sysCsrStrobe = 1'b1;
        rise_cnt     = 0;
        cur_nb       = nb;
        mosi_cap     = '0;
        busy_cnt     = 0;
        cs_err       = 0;
        exp_csn      = e.csn;
        exp_ovr      = 1'b0;
        @(negedge sysClk);
        sysCsrStrobe = 1'b0;
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        bit   timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (sysCsr[31] === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge sysClk);
        end
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s_timeout busy still %b after 2000 cycles, want 0", name, sysCsr[31]);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard queue empty, want 1 entry", name);
            return;
        end
        e = exp_q.pop_front();
        $display("xfer %s nb=%0d rx=%h mosi=%h pulses=%0d busy=%0d", name, e.nb,
                 sysCsr[23:0], mosi_cap, rise_cnt, busy_cnt);
        checks++;
        if (sysCsr[23:0] !== e.rx) begin
            errors++;
            $display("FAIL %s_rx got %h want %h", name, sysCsr[23:0], e.rx);
        end
        checks++;
        if (mosi_cap !== e.mosi) begin
            errors++;
            $display("FAIL %s_mosi got %h want %h", name, mosi_cap, e.mosi);
        end
        checks++;
        if (rise_cnt != e.nb) begin
            errors++;
            $display("FAIL %s_pulses got %0d want %0d", name, rise_cnt, e.nb);
        end
        checks++;
        if (busy_cnt != e.busy_cycles) begin
            errors++;
            $display("FAIL %s_busy got %0d want %0d", name, busy_cnt, e.busy_cycles);
        end
        checks++;
        if (cs_err != 0) begin
            errors++;
            $display("FAIL %s_cs got %0d bad cycles want 0 (csn want %b)", name, cs_err, e.csn);
        end
        checks++;
        if (sysCsr[29] !== e.badsel || sysCsr[30] !== exp_ovr) begin
            errors++;
            $display("FAIL %s_flags got badsel=%b ovr=%b want badsel=%b ovr=%b", name,
                     sysCsr[29], sysCsr[30], e.badsel, exp_ovr);
        end
        checks++;
        if (spiClk !== 1'b0 || spiMosi !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_lines got clk=%b mosi=%b want 0 0", name, spiClk, spiMosi);
        end
    endtask

    task automatic test_reset();
        sysReset = 1'b1;
        repeat (3) @(negedge sysClk);
        checks++;
        if (sysCsr !== 32'd0 || spiCsN !== '1 || spiClk !== 1'b0 || spiMosi !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got csr=%h csn=%b clk=%b mosi=%b want 0 111 0 0",
                     sysCsr, spiCsN, spiClk, spiMosi);
        end
        sysReset = 1'b0;
        @(negedge sysClk);
    endtask

    task automatic test_reset_mid();
        exp_t dropped;
        bit   seen_high;
        start_xfer(32'h17123456, 2'd1);
        seen_high = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (spiClk === 1'b1) begin
                seen_high = 1'b1;
                break;
            end
            @(negedge sysClk);
        end
        checks++;
        if (!seen_high) begin
            errors++;
            $display("FAIL reset_mid_wait spiClk got %b want 1 within 100 cycles", spiClk);
        end
        #2 sysReset = 1'b1;
        #1;
        checks++;
        if (spiCsN !== '1 || spiClk !== 1'b0 || sysCsr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got csn=%b clk=%b csr=%h want 111 0 00000000",
                     spiCsN, spiClk, sysCsr);
        end
        dropped = exp_q.pop_front();
        @(negedge sysClk);
        sysReset = 1'b0;
        repeat (3) @(negedge sysClk);
        checks++;
        if (sysCsr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_after got csr=%h want 00000000 (dropped nb=%0d)", sysCsr, dropped.nb);
        end
    endtask

    task automatic test_full24();
        start_xfer(32'h17A5A5A5, 2'd2);
        wait_done("full24");
    endtask

    task automatic test_one_bit();
        start_xfer(32'h00000001, 2'd1);
        wait_done("one_bit");
    endtask

    task automatic test_patterns();
        logic [31:0]      cmds [4] = '{32'h0B000ABC, 32'h07FF00C3, 32'h1F123456, 32'h02000005};
        logic [SEL_W-1:0] sels [4] = '{2'd0, 2'd1, 2'd0, 2'd2};
        for (int i = 0; i < 4; i++) begin
            start_xfer(cmds[i], sels[i]);
            wait_done($sformatf("pattern%0d", i));
        end
    endtask

    task automatic test_overrun();
        start_xfer(32'h0F00BEEF, 2'd2);
        repeat (10) @(negedge sysClk);
        sysGpioOut   = 32'h00000000;
        sysCsrStrobe = 1'b1;
        @(negedge sysClk);
        sysCsrStrobe = 1'b0;
        exp_ovr      = 1'b1;
        checks++;
        if (sysCsr[30] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got %b want 1", sysCsr[30]);
        end
        wait_done("overrun_first");
        start_xfer(32'h03000009, 2'd0);
        checks++;
        if (sysCsr[30] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got %b want 0", sysCsr[30]);
        end
        wait_done("overrun_next");
    endtask

    task automatic test_back_to_back();
        start_xfer(32'h00000001, 2'd1);
        repeat (15) @(negedge sysClk);
        sysGpioOut   = 32'h05000033;
        sysCsrStrobe = 1'b1;
        @(negedge sysClk);
        sysCsrStrobe = 1'b0;
        exp_ovr      = 1'b1;
        wait_done("busy_fall_strobe");
        repeat (3) @(negedge sysClk);
        checks++;
        if (sysCsr[31] !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall_no_start busy got %b want 0", sysCsr[31]);
        end
    endtask

    task automatic test_badsel();
        start_xfer(32'h0700FFAA, 2'd3);
        wait_done("badsel");
    endtask

    task automatic test_sel_change();
        start_xfer(32'h0F00C3A5, 2'd0);
        repeat (8) @(negedge sysClk);
        muxSel = 2'd1;
        wait_done("sel_change");
    endtask

    initial begin
        sysReset     = 1'b1;
        sysCsrStrobe = 1'b0;
        sysGpioOut   = '0;
        muxSel       = '0;
        slave_pat[0] = 24'hC30F1E;
        slave_pat[1] = 24'h814225;
        slave_pat[2] = 24'h5A5A5A;
        test_reset();
        test_reset_mid();
        test_full24();
        test_one_bit();
        test_patterns();
        test_overrun();
        test_back_to_back();
        test_badsel();
        test_sel_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
